// File: rtl/mem_access_if.sv
// Memory-access stage signal bundle: EX-side request, data bus, and write-back result.
// The stage itself connects through slave; the upstream/bus/write-back side uses master.
interface mem_access_if;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [1:0]  mem_access_op;
    logic [1:0]  mem_access_sz;
    logic        mem_load_unsigned;
    logic [31:0] data_i;
    logic [31:0] mem_addr;
    logic [4:0]  reg_addr;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg_addr;
    logic        addr_error;
    logic        addr_error_store;
    logic [31:0] bad_vaddr;

    modport slave (
        input  in_valid, flush, mem_access_op, mem_access_sz, mem_load_unsigned,
               data_i, mem_addr, reg_addr, bus_data_i, bus_stall,
        output in_ready, bus_address, bus_read, bus_write, bus_byte_enable, bus_data_o,
               wb_valid, wb_data, wb_reg_addr, addr_error, addr_error_store, bad_vaddr
    );

    modport master (
        output in_valid, flush, mem_access_op, mem_access_sz, mem_load_unsigned,
               data_i, mem_addr, reg_addr, bus_data_i, bus_stall,
        input  in_ready, bus_address, bus_read, bus_write, bus_byte_enable, bus_data_o,
               wb_valid, wb_data, wb_reg_addr, addr_error, addr_error_store, bad_vaddr
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: latches EX results, runs one bus transaction per
// aligned load/store, aligns/extends load data and presents a registered write-back.
module mem_access (
    input  logic      clk,
    input  logic      rst,
    mem_access_if.slave io
);
    localparam logic [1:0] OP_D2R  = 2'b00;
    localparam logic [1:0] OP_M2R  = 2'b01;
    localparam logic [1:0] OP_R2M  = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] data;
        logic [31:0] addr;
        logic [4:0]  rd;
    } req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        logic        err_st;
        logic [31:0] bad;
    } wb_t;

    state_t state_q, state_d;
    req_t   req_q;
    wb_t    wb_q, wb_d;
    logic   flush_q, flush_d;

    // Reserved op/size codes degrade to D2R / WORD before anything else sees them.
    logic [1:0] op_in, sz_in;
    logic       mis_in, accept;
    assign op_in  = (io.mem_access_op == 2'b11) ? OP_D2R  : io.mem_access_op;
    assign sz_in  = (io.mem_access_sz == 2'b11) ? SZ_WORD : io.mem_access_sz;
    assign mis_in = ((sz_in == SZ_HALF) && io.mem_addr[0]) ||
                    ((sz_in == SZ_WORD) && (io.mem_addr[1:0] != 2'b00));
    assign accept = io.in_valid && (state_q == IDLE) && !io.flush;

    assign io.in_ready = (state_q == IDLE);

    // Load alignment: pick the addressed lane(s) of the returned word.
    logic [3:0][7:0] rd_lanes;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;
    assign rd_lanes = io.bus_data_i;
    assign ld_byte  = rd_lanes[req_q.addr[1:0]];
    assign ld_half  = req_q.addr[1] ? io.bus_data_i[31:16] : io.bus_data_i[15:0];

    always_comb begin
        case (req_q.sz)
            SZ_BYTE: ld_data = req_q.uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = req_q.uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = io.bus_data_i;
        endcase
    end

    // Bus drive depends only on state and latched request, so reset drops it at once.
    always_comb begin
        io.bus_address     = '0;
        io.bus_read        = 1'b0;
        io.bus_write       = 1'b0;
        io.bus_byte_enable = '0;
        io.bus_data_o      = '0;
        if (state_q == ACCESS) begin
            io.bus_address = {req_q.addr[31:2], 2'b00};
            io.bus_read    = (req_q.op == OP_M2R);
            io.bus_write   = (req_q.op == OP_R2M);
            case (req_q.sz)
                SZ_BYTE: begin
                    io.bus_byte_enable = 4'b0001 << req_q.addr[1:0];
                    io.bus_data_o      = {4{req_q.data[7:0]}};
                end
                SZ_HALF: begin
                    io.bus_byte_enable = req_q.addr[1] ? 4'b1100 : 4'b0011;
                    io.bus_data_o      = {2{req_q.data[15:0]}};
                end
                default: begin
                    io.bus_byte_enable = 4'b1111;
                    io.bus_data_o      = req_q.data;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        wb_d    = '0;
        case (state_q)
            IDLE: begin
                flush_d = 1'b0;
                if (accept) begin
                    if (op_in == OP_D2R) begin
                        wb_d.valid = 1'b1;
                        wb_d.data  = io.data_i;
                        wb_d.rd    = io.reg_addr;
                    end else if (mis_in) begin
                        wb_d.valid  = 1'b1;
                        wb_d.err    = 1'b1;
                        wb_d.err_st = (op_in == OP_R2M);
                        wb_d.bad    = io.mem_addr;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A flush cannot abort the bus cycle; it only hides the result.
                if (io.flush) flush_d = 1'b1;
                if (!io.bus_stall) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    if (!(flush_q || io.flush)) begin
                        wb_d.valid = 1'b1;
                        if (req_q.op == OP_M2R) begin
                            wb_d.data = ld_data;
                            wb_d.rd   = req_q.rd;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            wb_q    <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            wb_q    <= wb_d;
            if (accept)
                req_q <= '{op: op_in, sz: sz_in, uns: io.mem_load_unsigned,
                           data: io.data_i, addr: io.mem_addr, rd: io.reg_addr};
        end
    end

    assign io.wb_valid         = wb_q.valid;
    assign io.wb_data          = wb_q.data;
    assign io.wb_reg_addr      = wb_q.rd;
    assign io.addr_error       = wb_q.err;
    assign io.addr_error_store = wb_q.err_st;
    assign io.bad_vaddr        = wb_q.bad;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected write-backs are queued at issue and
// popped by a monitor whenever wb_valid is seen.
module tb_mem_access;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_if bus_if ();
    mem_access dut (.clk(clk), .rst(rst), .io(bus_if));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        logic        err_st;
        logic [31:0] bad;
        logic        mem;
        logic [1:0]  opn;
        logic [1:0]  szn;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] d, input logic [31:0] a,
                                   input logic [4:0] rd, input logic [31:0] bus);
        exp_t e;
        logic [7:0]  b;
        logic [15:0] h;
        logic        mis;
        e = '{data: 32'h0, rd: 5'h0, err: 1'b0, err_st: 1'b0, bad: 32'h0, mem: 1'b0,
              opn: (op == 2'b11) ? 2'b00 : op, szn: (sz == 2'b11) ? 2'b10 : sz};
        mis = (e.szn == 2'b01 && a[0]) || (e.szn == 2'b10 && a[1:0] != 2'b00);
        case (a[1:0])
            2'd0: b = bus[7:0];
            2'd1: b = bus[15:8];
            2'd2: b = bus[23:16];
            default: b = bus[31:24];
        endcase
        h = a[1] ? bus[31:16] : bus[15:0];
        if (e.opn == 2'b00) begin
            e.data = d;
            e.rd   = rd;
        end else if (mis) begin
            e.err    = 1'b1;
            e.err_st = (e.opn == 2'b10);
            e.bad    = a;
        end else begin
            e.mem = 1'b1;
            if (e.opn == 2'b01) begin
                e.rd = rd;
                if (e.szn == 2'b00)      e.data = uns ? {24'h0, b} : {{24{b[7]}}, b};
                else if (e.szn == 2'b01) e.data = uns ? {16'h0, h} : {{16{h[15]}}, h};
                else                     e.data = bus;
            end
        end
        return e;
    endfunction

    // Issue one instruction; walk the bus phase checking drive, optionally flushing.
    task automatic run_op(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                          input logic [31:0] d, input logic [31:0] a, input logic [4:0] rd,
                          input int stalls, input int flush_at);
        exp_t e;
        logic [3:0]  be;
        logic [31:0] dout;
        e = model(op, sz, uns, d, a, rd, bus_if.bus_data_i);
        case (e.szn)
            2'b00:   begin be = 4'b0001 << a[1:0];             dout = {4{d[7:0]}};  end
            2'b01:   begin be = a[1] ? 4'b1100 : 4'b0011;      dout = {2{d[15:0]}}; end
            default: begin be = 4'b1111;                       dout = d;            end
        endcase
        chk("in_ready_idle", 32'(bus_if.in_ready), 32'd1);
        bus_if.mem_access_op     = op;
        bus_if.mem_access_sz     = sz;
        bus_if.mem_load_unsigned = uns;
        bus_if.data_i            = d;
        bus_if.mem_addr          = a;
        bus_if.reg_addr          = rd;
        bus_if.in_valid          = 1'b1;
        bus_if.bus_stall         = (stalls > 0);
        if (flush_at < 0) q.push_back(e);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        if (!e.mem) begin
            chk("no_bus", 32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
        end else begin
            for (int i = 0; i <= stalls; i++) begin
                chk("bus_rw", 32'({bus_if.bus_read, bus_if.bus_write}),
                    (e.opn == 2'b01) ? 32'd2 : 32'd1);
                chk("bus_addr", bus_if.bus_address, {a[31:2], 2'b00});
                chk("bus_be", 32'(bus_if.bus_byte_enable), 32'(be));
                chk("bus_do", bus_if.bus_data_o, dout);
                chk("in_ready_acc", 32'(bus_if.in_ready), 32'd0);
                bus_if.bus_stall = (i < stalls);
                bus_if.flush     = (i == flush_at);
                @(negedge clk);
            end
            bus_if.flush     = 1'b0;
            bus_if.bus_stall = 1'b0;
            chk("in_ready_done", 32'(bus_if.in_ready), 32'd1);
            chk("bus_idle", 32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.wb_valid) begin
                if (q.size() == 0) begin
                    chk("wb_unexpected", 32'(bus_if.wb_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_data", bus_if.wb_data, e.data);
                    chk("wb_reg_addr", 32'(bus_if.wb_reg_addr), 32'(e.rd));
                    chk("addr_error", 32'(bus_if.addr_error), 32'(e.err));
                    chk("addr_error_store", 32'(bus_if.addr_error_store), 32'(e.err_st));
                    chk("bad_vaddr", bus_if.bad_vaddr, e.bad);
                end
            end else begin
                chk("wb_rd_quiet", 32'(bus_if.wb_reg_addr), 32'd0);
                chk("err_quiet", 32'(bus_if.addr_error), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus_if.in_valid = 1'b0;  bus_if.flush = 1'b0;
        bus_if.mem_access_op = 2'b00;  bus_if.mem_access_sz = 2'b00;
        bus_if.mem_load_unsigned = 1'b0;
        bus_if.data_i = '0;  bus_if.mem_addr = '0;  bus_if.reg_addr = '0;
        bus_if.bus_data_i = '0;  bus_if.bus_stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", 32'(bus_if.wb_valid), 32'd0);
        chk("rst_wb_data", bus_if.wb_data, 32'd0);
        chk("rst_bad_vaddr", bus_if.bad_vaddr, 32'd0);
        chk("rst_bus", 32'({bus_if.bus_read, bus_if.bus_write, bus_if.bus_byte_enable}), 32'd0);
        chk("rst_bus_addr", bus_if.bus_address, 32'd0);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        rst = 1'b0;

        // D2R, then back-to-back D2R and faults
        run_op(2'b00, 2'b10, 1'b0, 32'h12345678, 32'h0, 5'd5, 0, -1);
        run_op(2'b00, 2'b00, 1'b0, 32'hCAFEF00D, 32'h7, 5'd9, 0, -1);
        run_op(2'b01, 2'b10, 1'b0, 32'h0, 32'h3002, 5'd4, 0, -1);
        run_op(2'b10, 2'b10, 1'b0, 32'h55, 32'h3002, 5'd4, 0, -1);
        run_op(2'b01, 2'b01, 1'b0, 32'h0, 32'h3001, 5'd6, 0, -1);
        run_op(2'b11, 2'b11, 1'b0, 32'hDEAD0001, 32'h3, 5'd8, 0, -1);

        // LB signed/unsigned at lane 3
        bus_if.bus_data_i = 32'h80FFFFFF;
        run_op(2'b01, 2'b00, 1'b0, 32'h0, 32'h1003, 5'd3, 0, -1);
        run_op(2'b01, 2'b00, 1'b1, 32'h0, 32'h1003, 5'd3, 0, -1);

        // SH upper half with three stall cycles
        run_op(2'b10, 2'b01, 1'b0, 32'hAAAABEEF, 32'h2002, 5'd7, 3, -1);

        // Flush during a stalled LW: bus finishes, result hidden
        run_op(2'b01, 2'b10, 1'b0, 32'h0, 32'h4000, 5'd2, 3, 1);
        // Flush on the completion edge itself
        run_op(2'b01, 2'b01, 1'b0, 32'h0, 32'h4002, 5'd2, 1, 1);

        // Flush in IDLE: input dropped
        bus_if.mem_access_op = 2'b00;  bus_if.data_i = 32'h11112222;  bus_if.reg_addr = 5'd1;
        bus_if.in_valid = 1'b1;  bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;  bus_if.flush = 1'b0;
        chk("flush_idle_wb", 32'(bus_if.wb_valid), 32'd0);

        // Random mix through the model
        for (int k = 0; k < 24; k++) begin
            bus_if.bus_data_i = $urandom;
            run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, {$urandom_range(0, 255), 2'($urandom_range(0, 3))},
                   5'($urandom_range(0, 31)), $urandom_range(0, 2), -1);
        end

        // Reset in the middle of a stalled access
        bus_if.mem_access_op = 2'b01;  bus_if.mem_access_sz = 2'b10;
        bus_if.mem_addr = 32'h5000;  bus_if.reg_addr = 5'd7;
        bus_if.in_valid = 1'b1;  bus_if.bus_stall = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("pre_rst_read", 32'(bus_if.bus_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_drop_read", 32'(bus_if.bus_read), 32'd0);
        chk("rst_drop_be", 32'(bus_if.bus_byte_enable), 32'd0);
        chk("rst_drop_addr", bus_if.bus_address, 32'd0);
        chk("rst_drop_wb", 32'({bus_if.wb_valid, bus_if.wb_reg_addr}), 32'd0);
        @(negedge clk);
        rst = 1'b0;  bus_if.bus_stall = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus_if.in_ready), 32'd1);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
